// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED array controller: mode encoding,
// frame geometry and the broadcast-address convention.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } led_mode_e;

  // Frame layout is {mode[1:0], duty[DUTY_W-1:0], addr[ADDR_W-1:0]}, MSB first.
  function automatic int frame_w(input int addr_w, input int duty_w);
    return 2 + duty_w + addr_w;
  endfunction

  // The all-ones address targets every LED.
  function automatic logic [31:0] bcast_addr(input int addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// Serial front end: synchronises SCK/DATA/LATCH, shifts bits on SCK rises,
// and presents the frame plus a length-check strobe on each LATCH rise.
module serial_frame_rx #(
  parameter int FRAME_W     = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic               gclk,
  input  logic               grst_n,
  input  logic               sck,
  input  logic               data,
  input  logic               latch,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid_len,
  output logic               latch_stb
);
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(FRAME_W);

  logic [SYNC_STAGES-1:0] sck_sync, data_sync, latch_sync;
  logic                   sck_d, latch_d;
  logic [FRAME_W-1:0]     shreg, shreg_nxt;
  logic [CNT_W-1:0]       bit_cnt, cnt_nxt;
  logic                   sck_rise;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sck_sync   <= '0;
      data_sync  <= '0;
      latch_sync <= '0;
      sck_d      <= 1'b0;
      latch_d    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], data};
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch};
      sck_d      <= sck_sync[SYNC_STAGES-1];
      latch_d    <= latch_sync[SYNC_STAGES-1];
      shreg      <= shreg_nxt;
      bit_cnt    <= latch_stb ? '0 : cnt_nxt;
    end
  end

  assign sck_rise  = sck_sync[SYNC_STAGES-1] & ~sck_d;
  assign latch_stb = latch_sync[SYNC_STAGES-1] & ~latch_d;

  // A bit arriving in the latch cycle is folded in before validation.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    if (sck_rise) begin
      shreg_nxt = {shreg[FRAME_W-2:0], data_sync[SYNC_STAGES-1]};
      if (bit_cnt != CNT_MAX) cnt_nxt = bit_cnt + CNT_W'(1);
    end
  end

  assign frame           = shreg_nxt;
  assign frame_valid_len = latch_stb && (cnt_nxt == CNT_LEN);

endmodule

// File: rtl/led_array_ctrl.sv
// LED array controller: decodes serial command frames into per-LED
// mode/duty registers and drives each LED from shared PWM and blink timebases.
module led_array_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_LED       = 19,
  parameter int ADDR_W      = 5,
  parameter int DUTY_W      = 4,
  parameter int BLINK_DIV   = 1 << 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SCK,
  input  logic             DATA,
  input  logic             LATCH,
  output logic [N_LED-1:0] LED,
  output logic             CMD_ACK,
  output logic             FRAME_ERR
);
  localparam int FRAME_W = frame_w(ADDR_W, DUTY_W);
  localparam int PRE_W   = $clog2(BLINK_DIV);
  localparam logic [ADDR_W-1:0] BCAST   = ADDR_W'(bcast_addr(ADDR_W));
  localparam logic [PRE_W-1:0]  PRE_TOP = PRE_W'(BLINK_DIV - 1);

  logic [FRAME_W-1:0] frame;
  logic               frame_valid_len, latch_stb;

  serial_frame_rx #(
    .FRAME_W    (FRAME_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .gclk           (CLK),
    .grst_n         (RESET),
    .sck            (SCK),
    .data           (DATA),
    .latch          (LATCH),
    .frame          (frame),
    .frame_valid_len(frame_valid_len),
    .latch_stb      (latch_stb)
  );

  logic [1:0]        f_mode;
  logic [DUTY_W-1:0] f_duty;
  logic [ADDR_W-1:0] f_addr;
  logic              is_bcast, addr_ok, accept, reject;

  assign f_mode   = frame[FRAME_W-1 -: 2];
  assign f_duty   = frame[ADDR_W +: DUTY_W];
  assign f_addr   = frame[ADDR_W-1:0];
  assign is_bcast = (f_addr == BCAST);
  assign addr_ok  = is_bcast || (32'(f_addr) < 32'(N_LED));
  assign accept   = frame_valid_len && addr_ok;
  assign reject   = latch_stb && !accept;

  logic [N_LED-1:0][1:0]        mode_q;
  logic [N_LED-1:0][DUTY_W-1:0] duty_q;
  logic [N_LED-1:0]             wr_en, led_nxt;
  logic [DUTY_W-1:0]            pwm_cnt;
  logic [PRE_W-1:0]             pre_cnt;
  logic                         blink_phase;

  for (genvar i = 0; i < N_LED; i++) begin : g_lane
    assign wr_en[i]   = accept && (is_bcast || f_addr == ADDR_W'(i));
    assign led_nxt[i] = (mode_q[i] == MODE_ON)
                      | ((mode_q[i] == MODE_BLINK) & blink_phase)
                      | ((mode_q[i] == MODE_PWM) & (pwm_cnt < duty_q[i]));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mode_q <= '0;
      duty_q <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        if (wr_en[i]) begin
          mode_q[i] <= f_mode;
          duty_q[i] <= f_duty;
        end
      end
    end
  end

  // Timebases free-run; config writes never disturb them.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pwm_cnt     <= '0;
      pre_cnt     <= '0;
      blink_phase <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + DUTY_W'(1);
      if (pre_cnt == PRE_TOP) begin
        pre_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      LED       <= '0;
      CMD_ACK   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      LED       <= led_nxt;
      CMD_ACK   <= accept;
      FRAME_ERR <= reject;
    end
  end

endmodule

// File: tb/tb_led_array_ctrl.sv
// Directed bench for led_array_ctrl with a cycle-indexed behavioural model
// of LED outputs and a windowed check of the ACK/ERR strobes.
module tb_led_array_ctrl;
  localparam int N    = 19;
  localparam int BD   = 8;
  localparam int SS   = 2;
  localparam int HOLD = SS + 2;
  localparam int PER  = 16;

  logic         CLK = 1'b0, RESET = 1'b1, SCK = 1'b0, DATA = 1'b0, LATCH = 1'b0;
  logic [N-1:0] LED;
  logic         CMD_ACK, FRAME_ERR;

  always #5 CLK = ~CLK;

  led_array_ctrl #(
    .N_LED(N), .ADDR_W(5), .DUTY_W(4), .BLINK_DIV(BD), .SYNC_STAGES(SS)
  ) dut (
    .CLK(CLK), .RESET(RESET), .SCK(SCK), .DATA(DATA), .LATCH(LATCH),
    .LED(LED), .CMD_ACK(CMD_ACK), .FRAME_ERR(FRAME_ERR)
  );

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   m_mode [N];
  int   m_duty [N];
  bit   in_win = 1'b0;
  int   win_ack = 0, win_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // LED value registered at the c-th clock edge after reset release:
  // it sees pwm count (c-1) mod 16 and blink phase floor((c-1)/BD) mod 2.
  function automatic logic [N-1:0] model_led(input int c);
    logic [N-1:0] v;
    v = '0;
    if (c >= 1) begin
      for (int i = 0; i < N; i++) begin
        case (m_mode[i])
          1:       v[i] = 1'b1;
          2:       v[i] = (((c - 1) / BD) % 2) == 1;
          3:       v[i] = ((c - 1) % PER) < m_duty[i];
          default: v[i] = 1'b0;
        endcase
      end
    end
    return v;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (!in_win) begin
      chk("led_model", 64'(LED), 64'(model_led(cyc)));
      chk("strobes_idle", 64'({CMD_ACK, FRAME_ERR}), 64'(0));
    end else begin
      win_ack += int'(CMD_ACK);
      win_err += int'(FRAME_ERR);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = 0;
      m_duty[i] = 0;
    end
  endtask

  task automatic pulse_reset(input int n);
    RESET = 1'b0;
    model_clear();
    wait_cyc(n);
    RESET = 1'b1;
    wait_cyc(1);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DATA = v[i];
      wait_cyc(HOLD);
      SCK = 1'b1;
      wait_cyc(HOLD);
      SCK = 1'b0;
      wait_cyc(HOLD);
    end
  endtask

  // Raise LATCH; the model takes the spec's verdict on (nbits, frame) at once,
  // DUT outputs are excused until the LED has had SS+4 cycles to settle.
  task automatic latch_frame(input int nbits, input logic [10:0] fr);
    int  addr;
    bit  ok;
    addr = int'(fr[4:0]);
    ok   = (nbits == 11) && (addr < N || addr == 31);
    win_ack = 0;
    win_err = 0;
    LATCH  = 1'b1;
    in_win = 1'b1;
    if (ok) begin
      for (int i = 0; i < N; i++) begin
        if (addr == 31 || addr == i) begin
          m_mode[i] = int'(fr[10:9]);
          m_duty[i] = int'(fr[8:5]);
        end
      end
    end
    wait_cyc(SS + 4);
    in_win = 1'b0;
    chk("ack_pulses", 64'(win_ack), 64'(ok));
    chk("err_pulses", 64'(win_err), 64'(!ok));
    wait_cyc(2);
    LATCH = 1'b0;
    wait_cyc(HOLD);
  endtask

  task automatic send_frame(input logic [1:0] mode, input logic [3:0] duty, input logic [4:0] addr);
    send_bits(32'({mode, duty, addr}), 11);
    latch_frame(11, {mode, duty, addr});
  endtask

  // Sample one LED on 64 consecutive falling edges: count highs and
  // (circular) high runs.
  task automatic measure(input int idx, output int highs, output int runs);
    logic [63:0] s;
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      s[k] = LED[idx];
    end
    highs = 0;
    runs  = 0;
    for (int k = 0; k < 64; k++) begin
      highs += int'(s[k]);
      if (s[k] && !s[(k + 63) % 64]) runs++;
    end
    wait_cyc(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hi, rn, tog, neq, ones;
    logic [N-1:0] prev;
    model_clear();
    #2 RESET = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RESET = 1'b1;
    wait_cyc(1000);
    chk("reset_idle_led", 64'(LED), 64'(0));

    // ON then OFF on LED 3
    send_frame(2'b01, 4'h0, 5'd3);
    chk("on_led3", 64'(LED), 64'(19'h00008));
    send_frame(2'b00, 4'h9, 5'd3);
    chk("off_led3", 64'(LED), 64'(0));

    // PWM on LED 7 at duty 4, 0 and 15
    send_frame(2'b11, 4'd4, 5'd7);
    measure(7, hi, rn);
    chk("pwm4_highs", 64'(hi), 64'(16));
    chk("pwm4_runs", 64'(rn), 64'(4));
    send_frame(2'b11, 4'd0, 5'd7);
    measure(7, hi, rn);
    chk("pwm0_highs", 64'(hi), 64'(0));
    send_frame(2'b11, 4'd15, 5'd7);
    measure(7, hi, rn);
    chk("pwm15_highs", 64'(hi), 64'(60));
    chk("pwm15_runs", 64'(rn), 64'(4));

    // Broadcast blink: all LEDs in lock-step, toggling every BD cycles
    send_frame(2'b10, 4'h0, 5'd31);
    @(negedge CLK);
    prev = LED;
    tog = 0;
    neq = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge CLK);
      if (LED != '0 && LED != '1) neq++;
      if (LED != prev) tog++;
      prev = LED;
    end
    chk("blink_lockstep", 64'(neq), 64'(0));
    chk("blink_toggles", 64'(tog), 64'(64 / BD));
    wait_cyc(1);

    send_frame(2'b01, 4'h0, 5'd5);
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      ones += int'(LED[5]);
    end
    chk("led5_steady", 64'(ones), 64'(16));
    wait_cyc(1);

    // Rejected frames: model keeps state, bench expects FRAME_ERR only
    send_bits(32'h0A1, 10);
    latch_frame(10, 11'h0A1);
    send_bits(32'h201, 12);
    latch_frame(12, 11'h201);
    send_frame(2'b01, 4'h0, 5'd25);
    latch_frame(0, 11'h000);

    // Reset mid-frame, then a clean frame to LED 0
    send_bits(32'h2A, 6);
    pulse_reset(3);
    send_frame(2'b01, 4'h0, 5'd0);
    chk("post_reset_led0", 64'(LED), 64'(19'h00001));

    // Last SCK rise and LATCH rise land together
    send_bits(32'({2'b01, 4'h0, 5'd2}) >> 1, 10);
    DATA = 1'b0;
    wait_cyc(HOLD);
    SCK = 1'b1;
    latch_frame(11, {2'b01, 4'h0, 5'd2});
    SCK = 1'b0;
    wait_cyc(HOLD);
    chk("same_cycle_led", 64'(LED), 64'(19'h00005));

    wait_cyc(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
